// File: rtl/hash_pkg.sv
// Shared definitions for the n-way MAC hash bucket: entry layout, default
// entry lifetime and the controller state encoding.
package hash_pkg;

    localparam int ENTRY_W   = 80;
    localparam int PM_LSB    = 0;
    localparam int PM_W      = 16;
    localparam int MAC_LSB   = 16;
    localparam int MAC_W     = 48;
    localparam int AGE_LSB   = 64;
    localparam int AGE_W     = 10;
    localparam int VALID_BIT = 79;

    localparam logic [AGE_W-1:0] LIVE_TH_DEF = 10'd150;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_IDLE   = 4'd1,
        S_RD     = 4'd2,
        S_CMP    = 4'd3,
        S_LEARN  = 4'd4,
        S_LOOKUP = 4'd5,
        S_AGE_RD = 4'd6,
        S_AGE_WR = 4'd7,
        S_GAP    = 4'd8
    } state_t;

    function automatic logic [ENTRY_W-1:0] make_entry(input logic [MAC_W-1:0] mac,
                                                      input logic [PM_W-1:0]  pm,
                                                      input logic [AGE_W-1:0] age);
        return {1'b1, 5'b0, age, mac, pm};
    endfunction

endpackage

// File: rtl/hash_way_ram.sv
// One way of the bucket table: single-port, synchronous read (1 cycle),
// write-first so a write also shows the new word on rdata.
module hash_way_ram
    import hash_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [ENTRY_W-1:0] wdata,
    output logic [ENTRY_W-1:0] rdata
);

    logic [ENTRY_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/hash_nway_bucket.sv
// N-way associative MAC table: learn/lookup on one bucket per request plus
// background aging, all serialised through one controller FSM.
module hash_nway_bucket
    import hash_pkg::*;
#(
    parameter int               WAYS           = 2,
    parameter int               ADDR_W         = 10,
    parameter logic [AGE_W-1:0] LIVE_TH        = LIVE_TH_DEF,
    parameter bit               REPLACE_OLDEST = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              se_source,
    input  logic [47:0]       se_mac,
    input  logic [15:0]       se_portmap,
    input  logic [ADDR_W-1:0] se_hash,
    input  logic              se_req,
    output logic              se_ack,
    output logic              se_nak,
    output logic [15:0]       se_result,
    input  logic              aging_req,
    output logic              aging_ack,
    output logic              init_done,
    output logic [3:0]        dbg_state
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  init_cnt, aging_addr, addr_q, ram_addr;
    logic               src_q, age_op;
    logic [MAC_W-1:0]   mac_q;
    logic [PM_W-1:0]    pm_q;
    logic [ENTRY_W-1:0] ram_rdata [WAYS];
    logic [ENTRY_W-1:0] ram_wdata [WAYS];
    logic [ENTRY_W-1:0] rdata_q   [WAYS];
    logic [ENTRY_W-1:0] age_nx    [WAYS];
    logic [ENTRY_W-1:0] age_wdata [WAYS];
    logic [WAYS-1:0]    ram_we;
    logic               hit, inv, dec_ok;
    logic [1:0]         hit_idx, inv_idx, old_idx, dec_way;
    logic [PM_W-1:0]    hit_pm, dec_pm;
    logic [AGE_W-1:0]   old_age;

    assign dbg_state = state;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        hash_way_ram #(.ADDR_W(ADDR_W)) u_ram (
            .clk   (clk),
            .we    (ram_we[g]),
            .addr  (ram_addr),
            .wdata (ram_wdata[g]),
            .rdata (ram_rdata[g])
        );
    end

    // se_req is level-held by the requester until the ack/nak pulse; it is taken
    // only in IDLE and always wins over aging_req, which is taken in IDLE otherwise.
    always_comb begin
        state_nx = state;
        case (state)
            S_INIT:   if (init_cnt == ADDR_MAX) state_nx = S_IDLE;
            S_IDLE:   if (se_req || aging_req) state_nx = S_RD;
            S_RD:     state_nx = age_op ? S_AGE_RD : S_CMP;
            S_CMP:    state_nx = src_q ? S_LEARN : S_LOOKUP;
            S_LEARN:  state_nx = S_GAP;
            S_LOOKUP: state_nx = S_GAP;
            S_AGE_RD: state_nx = S_AGE_WR;
            S_AGE_WR: state_nx = S_GAP;
            S_GAP:    state_nx = S_IDLE;
            default:  state_nx = S_INIT;
        endcase
    end

    always_comb begin
        ram_addr = addr_q;
        ram_we   = '0;
        for (int w = 0; w < WAYS; w++) ram_wdata[w] = '0;
        case (state)
            S_INIT: begin
                ram_addr = init_cnt;
                ram_we   = '1;
            end
            S_IDLE: ram_addr = se_req ? se_hash : aging_addr;
            S_LEARN: begin
                for (int w = 0; w < WAYS; w++) begin
                    ram_wdata[w] = make_entry(mac_q, pm_q, LIVE_TH);
                    ram_we[w]    = dec_ok && (dec_way == 2'(w));
                end
            end
            S_AGE_WR: begin
                ram_we = '1;
                for (int w = 0; w < WAYS; w++) ram_wdata[w] = age_wdata[w];
            end
            default: ;
        endcase
    end

    // Descending scans so the lowest-index match is the one that sticks.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_pm  = '0;
        inv     = 1'b0;
        inv_idx = '0;
        old_idx = '0;
        old_age = rdata_q[0][AGE_LSB +: AGE_W];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rdata_q[w][VALID_BIT] && rdata_q[w][MAC_LSB +: MAC_W] == mac_q) begin
                hit     = 1'b1;
                hit_idx = 2'(w);
                hit_pm  = rdata_q[w][PM_LSB +: PM_W];
            end
            if (!rdata_q[w][VALID_BIT]) begin
                inv     = 1'b1;
                inv_idx = 2'(w);
            end
        end
        for (int w = 1; w < WAYS; w++) begin
            if (rdata_q[w][AGE_LSB +: AGE_W] < old_age) begin
                old_age = rdata_q[w][AGE_LSB +: AGE_W];
                old_idx = 2'(w);
            end
        end
    end

    // Expired (age 0) and invalid ways both collapse to an all-zero word.
    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            age_nx[w] = '0;
            if (rdata_q[w][VALID_BIT] && rdata_q[w][AGE_LSB +: AGE_W] != '0) begin
                age_nx[w]                      = rdata_q[w];
                age_nx[w][AGE_LSB +: AGE_W]    = rdata_q[w][AGE_LSB +: AGE_W] - 1'b1;
                age_nx[w][VALID_BIT-1 -: 5]    = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= S_INIT;
            init_cnt   <= '0;
            aging_addr <= '0;
            addr_q     <= '0;
            src_q      <= 1'b0;
            age_op     <= 1'b0;
            mac_q      <= '0;
            pm_q       <= '0;
            dec_ok     <= 1'b0;
            dec_way    <= '0;
            dec_pm     <= '0;
            se_ack     <= 1'b0;
            se_nak     <= 1'b0;
            se_result  <= '0;
            aging_ack  <= 1'b0;
            init_done  <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                rdata_q[w]   <= '0;
                age_wdata[w] <= '0;
            end
        end else begin
            state     <= state_nx;
            se_ack    <= 1'b0;
            se_nak    <= 1'b0;
            aging_ack <= 1'b0;
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == ADDR_MAX) init_done <= 1'b1;
                end
                S_IDLE: begin
                    if (se_req) begin
                        addr_q <= se_hash;
                        mac_q  <= se_mac;
                        pm_q   <= se_portmap;
                        src_q  <= se_source;
                        age_op <= 1'b0;
                    end else if (aging_req) begin
                        addr_q <= aging_addr;
                        age_op <= 1'b1;
                    end
                end
                S_RD: for (int w = 0; w < WAYS; w++) rdata_q[w] <= ram_rdata[w];
                S_CMP: begin
                    dec_pm <= hit_pm;
                    if (!src_q) begin
                        dec_ok  <= hit;
                        dec_way <= hit_idx;
                    end else if (hit) begin
                        dec_ok  <= 1'b1;
                        dec_way <= hit_idx;
                    end else if (inv) begin
                        dec_ok  <= 1'b1;
                        dec_way <= inv_idx;
                    end else begin
                        dec_ok  <= REPLACE_OLDEST;
                        dec_way <= old_idx;
                    end
                end
                S_LEARN: begin
                    se_ack <= dec_ok;
                    se_nak <= !dec_ok;
                end
                S_LOOKUP: begin
                    se_ack <= dec_ok;
                    se_nak <= !dec_ok;
                    if (dec_ok) se_result <= dec_pm;
                end
                S_AGE_RD: begin
                    for (int w = 0; w < WAYS; w++) age_wdata[w] <= age_nx[w];
                    aging_ack <= (addr_q == ADDR_MAX);
                end
                S_AGE_WR: aging_addr <= aging_addr + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_nway_bucket.sv
// Bench for hash_nway_bucket: a REPLACE_OLDEST=0/1 pair sharing stimulus plus a
// small short-lived table (16 buckets, lifetime 1) for the aging expiry case.
module tb_hash_nway_bucket;
    import hash_pkg::*;

    localparam int W = 34;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        se_source = 1'b0;
    logic [47:0] se_mac = '0;
    logic [15:0] se_portmap = '0;
    logic [9:0]  se_hash = '0;
    logic        se_req = 1'b0;
    logic        aging_req = 1'b0;
    logic        a_se_req = 1'b0;
    logic        a_aging_req = 1'b0;

    logic        ack0, nak0, aack0, idone0, ack1, nak1, aack1, idone1;
    logic        a_ack, a_nak, a_aack, a_idone;
    logic [15:0] res0, res1, a_res;
    logic [3:0]  dbg0, dbg1, a_dbg;

    hash_nway_bucket #(.WAYS(2), .ADDR_W(10), .LIVE_TH(10'd150), .REPLACE_OLDEST(1'b0)) u_dut0 (
        .clk(clk), .rstn(rstn), .se_source(se_source), .se_mac(se_mac), .se_portmap(se_portmap),
        .se_hash(se_hash), .se_req(se_req), .se_ack(ack0), .se_nak(nak0), .se_result(res0),
        .aging_req(aging_req), .aging_ack(aack0), .init_done(idone0), .dbg_state(dbg0));

    hash_nway_bucket #(.WAYS(2), .ADDR_W(10), .LIVE_TH(10'd150), .REPLACE_OLDEST(1'b1)) u_dut1 (
        .clk(clk), .rstn(rstn), .se_source(se_source), .se_mac(se_mac), .se_portmap(se_portmap),
        .se_hash(se_hash), .se_req(se_req), .se_ack(ack1), .se_nak(nak1), .se_result(res1),
        .aging_req(aging_req), .aging_ack(aack1), .init_done(idone1), .dbg_state(dbg1));

    hash_nway_bucket #(.WAYS(2), .ADDR_W(4), .LIVE_TH(10'd1), .REPLACE_OLDEST(1'b0)) u_duta (
        .clk(clk), .rstn(rstn), .se_source(se_source), .se_mac(se_mac), .se_portmap(se_portmap),
        .se_hash(se_hash[3:0]), .se_req(a_se_req), .se_ack(a_ack), .se_nak(a_nak), .se_result(a_res),
        .aging_req(a_aging_req), .aging_ack(a_aack), .init_done(a_idone), .dbg_state(a_dbg));

    // clock / reset
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];
    int aack_cnt0 = 0, aack_cnt1 = 0, aack_cnt_a = 0;

    always @(negedge clk) begin
        if (aack0)  aack_cnt0  <= aack_cnt0 + 1;
        if (aack1)  aack_cnt1  <= aack_cnt1 + 1;
        if (a_aack) aack_cnt_a <= aack_cnt_a + 1;
    end

    typedef struct {
        logic        src;
        logic [47:0] mac;
        logic [15:0] pm;
        logic [9:0]  hash;
        logic        ok0;
        logic [15:0] r0;
        logic        ok1;
        logic [15:0] r1;
    } vec_t;
    vec_t vec[17];

    localparam logic [47:0] MAC_A = 48'h001122334455;
    localparam logic [47:0] MAC_B = 48'h66778899AABB;
    localparam logic [47:0] MAC_C = 48'h0C0C0C0C0C0C;
    localparam logic [47:0] MAC_D = 48'h0000DEADBEEF;
    localparam logic [47:0] MAC_E = 48'h0A0B0C0D0E0F;
    localparam logic [47:0] MAC_X = 48'h123456789ABC;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // driver: one search; sel=1 targets the short-lived table
    task automatic search(input bit sel, input bit with_age, input logic src, input logic [47:0] mac,
                          input logic [15:0] pm, input logic [9:0] hash, input logic ok0,
                          input logic [15:0] r0, input logic ok1, input logic [15:0] r1,
                          input string name);
        logic [W-1:0] e;
        int lat;
        bit got;
        @(negedge clk);
        se_source  = src;
        se_mac     = mac;
        se_portmap = pm;
        se_hash    = hash;
        if (sel) a_se_req = 1'b1;
        else se_req = 1'b1;
        if (with_age) aging_req = 1'b1;
        exp_q.push_back({ok0, r0, ok1, r1});
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            got = sel ? (a_ack | a_nak) : (ack0 | nak0 | ack1 | nak1);
        end
        se_req   = 1'b0;
        a_se_req = 1'b0;
        e = exp_q.pop_front();
        check({name, " latency"}, 64'(lat), 64'd4);
        if (sel) begin
            check({name, " ack"}, a_ack, e[33]);
            check({name, " nak"}, a_nak, !e[33]);
            check({name, " result"}, a_res, e[32:17]);
        end else begin
            check({name, " ack0"}, ack0, e[33]);
            check({name, " nak0"}, nak0, !e[33]);
            check({name, " result0"}, res0, e[32:17]);
            check({name, " ack1"}, ack1, e[16]);
            check({name, " nak1"}, nak1, !e[16]);
            check({name, " result1"}, res1, e[15:0]);
        end
    endtask

    task automatic age_one(input bit sel);
        @(negedge clk);
        if (sel) a_aging_req = 1'b1;
        else aging_req = 1'b1;
        @(negedge clk);
        a_aging_req = 1'b0;
        aging_req   = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // waits for init_done after a reset release, counting rising edges and stray responses
    task automatic wait_init(output int t0, output int ta, output int resp);
        int cyc;
        cyc = 0;
        t0 = -1;
        ta = -1;
        resp = 0;
        while (t0 < 0 && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (idone0) t0 = cyc;
            if (a_idone && ta < 0) ta = cyc;
            if (ack0 | nak0 | ack1 | nak1) resp++;
        end
    endtask

    initial begin
        int t0, ta, resp, n;
        bit seen;

        vec[0]  = '{1'b1, MAC_A, 16'h0004, 10'd5,    1'b1, 16'h0000, 1'b1, 16'h0000};
        vec[1]  = '{1'b0, MAC_A, 16'h0000, 10'd5,    1'b1, 16'h0004, 1'b1, 16'h0004};
        vec[2]  = '{1'b0, MAC_D, 16'h0000, 10'd5,    1'b0, 16'h0004, 1'b0, 16'h0004};
        vec[3]  = '{1'b1, MAC_A, 16'h0008, 10'd5,    1'b1, 16'h0004, 1'b1, 16'h0004};
        vec[4]  = '{1'b0, MAC_A, 16'h0000, 10'd5,    1'b1, 16'h0008, 1'b1, 16'h0008};
        vec[5]  = '{1'b1, MAC_B, 16'h0010, 10'd5,    1'b1, 16'h0008, 1'b1, 16'h0008};
        vec[6]  = '{1'b0, MAC_B, 16'h0000, 10'd5,    1'b1, 16'h0010, 1'b1, 16'h0010};
        vec[7]  = '{1'b0, MAC_A, 16'h0000, 10'd6,    1'b0, 16'h0010, 1'b0, 16'h0010};
        vec[8]  = '{1'b1, MAC_E, 16'h8001, 10'd1023, 1'b1, 16'h0010, 1'b1, 16'h0010};
        vec[9]  = '{1'b0, MAC_E, 16'h0000, 10'd1023, 1'b1, 16'h8001, 1'b1, 16'h8001};
        vec[10] = '{1'b0, 48'h0, 16'h0000, 10'd0,    1'b0, 16'h8001, 1'b0, 16'h8001};
        vec[11] = '{1'b1, MAC_A, 16'h0008, 10'd5,    1'b1, 16'h8001, 1'b1, 16'h8001};
        vec[12] = '{1'b1, MAC_C, 16'h0020, 10'd5,    1'b0, 16'h8001, 1'b1, 16'h8001};
        vec[13] = '{1'b0, MAC_B, 16'h0000, 10'd5,    1'b1, 16'h0010, 1'b0, 16'h8001};
        vec[14] = '{1'b0, MAC_C, 16'h0000, 10'd5,    1'b0, 16'h0010, 1'b1, 16'h0020};
        vec[15] = '{1'b0, MAC_A, 16'h0000, 10'd5,    1'b1, 16'h0008, 1'b1, 16'h0008};
        vec[16] = '{1'b0, MAC_E, 16'h0000, 10'd1023, 1'b1, 16'h8001, 1'b1, 16'h8001};

        #3 rstn = 1'b0;
        #20;
        check("rst ack", ack0, 1'b0);
        check("rst nak", nak0, 1'b0);
        check("rst result", res0, 16'h0);
        check("rst aging_ack", aack0, 1'b0);
        check("rst init_done", idone0, 1'b0);
        check("rst state", dbg0, S_INIT);
        check("rst state1", dbg1, S_INIT);

        // request held during INIT must be ignored
        @(negedge clk);
        rstn       = 1'b1;
        se_source  = 1'b0;
        se_mac     = MAC_A;
        se_req     = 1'b1;
        wait_init(t0, ta, resp);
        se_req = 1'b0;
        check("init cycles", 64'(t0), 64'd1024);
        check("init cycles small", 64'(ta), 64'd16);
        check("no resp in init", 64'(resp), 64'd0);
        check("init_done1", idone1, 1'b1);

        for (int i = 0; i < 11; i++)
            search(1'b0, 1'b0, vec[i].src, vec[i].mac, vec[i].pm, vec[i].hash,
                   vec[i].ok0, vec[i].r0, vec[i].ok1, vec[i].r1, $sformatf("vec%0d", i));

        for (int i = 0; i < 1023; i++) age_one(1'b0);
        check("aging_ack before last", 64'(aack_cnt0), 64'd0);
        age_one(1'b0);
        check("aging_ack sweep0", 64'(aack_cnt0), 64'd1);
        check("aging_ack sweep1", 64'(aack_cnt1), 64'd1);

        for (int i = 11; i < 17; i++)
            search(1'b0, 1'b0, vec[i].src, vec[i].mac, vec[i].pm, vec[i].hash,
                   vec[i].ok0, vec[i].r0, vec[i].ok1, vec[i].r1, $sformatf("vec%0d", i));

        // expiry on the lifetime-1 table
        search(1'b1, 1'b0, 1'b1, MAC_X, 16'h0042, 10'd3, 1'b1, 16'h0000, 1'b0, 16'h0, "exp learn");
        for (int i = 0; i < 16; i++) age_one(1'b1);
        check("exp aging_ack 1", 64'(aack_cnt_a), 64'd1);
        search(1'b1, 1'b0, 1'b0, MAC_X, 16'h0000, 10'd3, 1'b1, 16'h0042, 1'b0, 16'h0, "exp alive");
        for (int i = 0; i < 16; i++) age_one(1'b1);
        check("exp aging_ack 2", 64'(aack_cnt_a), 64'd2);
        search(1'b1, 1'b0, 1'b0, MAC_X, 16'h0000, 10'd3, 1'b0, 16'h0042, 1'b0, 16'h0, "exp gone");

        // contention: search and aging together, search must win
        search(1'b0, 1'b1, 1'b0, MAC_A, 16'h0000, 10'd5, 1'b1, 16'h0008, 1'b1, 16'h0008, "contend");
        seen = 1'b0;
        n = 0;
        while (!seen && n < 12) begin
            @(negedge clk);
            n++;
            seen = (dbg0 == S_AGE_WR);
        end
        aging_req = 1'b0;
        check("contend aging served", seen, 1'b1);
        repeat (3) @(negedge clk);

        // reset while a learn sits in CMP
        @(negedge clk);
        se_source  = 1'b1;
        se_mac     = 48'h00000000F00D;
        se_portmap = 16'h0001;
        se_hash    = 10'd7;
        se_req     = 1'b1;
        seen = 1'b0;
        n = 0;
        while (!seen && n < 10) begin
            @(negedge clk);
            n++;
            seen = (dbg0 == S_CMP);
        end
        check("reach cmp", seen, 1'b1);
        #2 rstn = 1'b0;
        se_req = 1'b0;
        #1;
        check("midrst ack", ack0 | ack1, 1'b0);
        check("midrst nak", nak0 | nak1, 1'b0);
        check("midrst result", res0, 16'h0);
        check("midrst init_done", idone0, 1'b0);
        check("midrst state", dbg0, S_INIT);
        @(negedge clk);
        rstn = 1'b1;
        wait_init(t0, ta, resp);
        check("reinit cycles", 64'(t0), 64'd1024);
        check("reinit no resp", 64'(resp), 64'd0);
        search(1'b0, 1'b0, 1'b0, MAC_A, 16'h0000, 10'd5, 1'b0, 16'h0000, 1'b0, 16'h0000, "after reinit");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
